// File: rtl/rename_register_file_pkg.sv
// Shared sizes, the empty-tag constant and the commit bundle for the rename register file.
// Commit-to-read forwarding is built only when RF_COMMIT_FWD_EN is defined.
package rename_register_file_pkg;
   localparam int XLEN       = 32;
   localparam int TAG_W      = 6;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [TAG_W-1:0] ZERO_TAG = '0;

   typedef struct packed {
      logic                  valid;
      logic [TAG_W-1:0]      tag;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       value;
   } commit_t;
endpackage

// File: rtl/rename_register_file_if.sv
// Commit, rename and operand-read bundle between the issue unit/ROB (master)
// and the rename register file (slave).
interface rename_register_file_if
   import rename_register_file_pkg::*;
#(
   parameter int XLEN       = rename_register_file_pkg::XLEN,
   parameter int TAG_W      = rename_register_file_pkg::TAG_W,
   parameter int NUM_READ   = 2,
   parameter int NUM_COMMIT = 2
);
   logic                             rdy;
   logic                             flush;
   logic [NUM_COMMIT-1:0]            commit_valid;
   logic [NUM_COMMIT*TAG_W-1:0]      commit_tag;
   logic [NUM_COMMIT*REG_ADDR_W-1:0] commit_rd;
   logic [NUM_COMMIT*XLEN-1:0]       commit_value;
   logic                             issue_valid;
   logic [REG_ADDR_W-1:0]            issue_rd;
   logic [TAG_W-1:0]                 issue_tag;
   logic [NUM_READ*REG_ADDR_W-1:0]   rd_addr;
   logic [NUM_READ*XLEN-1:0]         rd_val;
   logic [NUM_READ*TAG_W-1:0]        rd_tag;
   logic [NUM_READ-1:0]              rd_busy;

   modport master (
      output rdy, flush, commit_valid, commit_tag, commit_rd, commit_value,
             issue_valid, issue_rd, issue_tag, rd_addr,
      input  rd_val, rd_tag, rd_busy
   );

   modport slave (
      input  rdy, flush, commit_valid, commit_tag, commit_rd, commit_value,
             issue_valid, issue_rd, issue_tag, rd_addr,
      output rd_val, rd_tag, rd_busy
   );
endinterface

// File: rtl/rename_register_file_read_port.sv
// One combinational operand read port. With RF_COMMIT_FWD_EN defined it also
// forwards a same-cycle commit whose tag matches the register's current rename tag.
module rf_read_port
   import rename_register_file_pkg::*;
#(
   parameter int XLEN  = rename_register_file_pkg::XLEN,
   parameter int TAG_W = rename_register_file_pkg::TAG_W
`ifdef RF_COMMIT_FWD_EN
   , parameter int NUM_COMMIT = 2
`endif
) (
   input  logic [REG_ADDR_W-1:0]            addr,
   input  logic [NUM_REGS*XLEN-1:0]         reg_flat,
   input  logic [NUM_REGS*TAG_W-1:0]        tag_flat,
   input  logic [NUM_REGS-1:0]              busy_flat,
`ifdef RF_COMMIT_FWD_EN
   input  logic [NUM_COMMIT-1:0]            commit_valid,
   input  logic [NUM_COMMIT*TAG_W-1:0]      commit_tag,
   input  logic [NUM_COMMIT*REG_ADDR_W-1:0] commit_rd,
   input  logic [NUM_COMMIT*XLEN-1:0]       commit_value,
`endif
   output logic [XLEN-1:0]                  val,
   output logic [TAG_W-1:0]                 tag,
   output logic                             busy
);
   logic [TAG_W-1:0] stored_tag;

   always_comb begin
      stored_tag = tag_flat[addr*TAG_W +: TAG_W];
      val        = reg_flat[addr*XLEN +: XLEN];
      busy       = busy_flat[addr];
      tag        = busy_flat[addr] ? stored_tag : TAG_W'(ZERO_TAG);
`ifdef RF_COMMIT_FWD_EN
      // Ascending scan: the youngest matching commit port is assigned last and wins.
      for (int c = 0; c < NUM_COMMIT; c++) begin
         if (commit_valid[c] && commit_rd[c*REG_ADDR_W +: REG_ADDR_W] == addr &&
             addr != '0 && commit_tag[c*TAG_W +: TAG_W] == stored_tag) begin
            val  = commit_value[c*XLEN +: XLEN];
            busy = 1'b0;
            tag  = TAG_W'(ZERO_TAG);
         end
      end
`endif
      if (addr == '0) begin
         val  = '0;
         busy = 1'b0;
         tag  = TAG_W'(ZERO_TAG);
      end
   end
endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags and busy bits.
// Define RF_COMMIT_FWD_EN to forward same-cycle commits onto the read ports.
module rename_register_file
   import rename_register_file_pkg::*;
#(
   parameter int XLEN       = rename_register_file_pkg::XLEN,
   parameter int TAG_W      = rename_register_file_pkg::TAG_W,
   parameter int NUM_READ   = 2,
   parameter int NUM_COMMIT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   rename_register_file_if.slave     bus
);
   logic [XLEN-1:0]            regs [NUM_REGS];
   logic [TAG_W-1:0]           tags [NUM_REGS];
   logic [NUM_REGS-1:0]        busy;
   logic [NUM_REGS*XLEN-1:0]   reg_flat;
   logic [NUM_REGS*TAG_W-1:0]  tag_flat;

   logic [REG_ADDR_W-1:0]      cm_rd  [NUM_COMMIT];
   logic [TAG_W-1:0]           cm_tag [NUM_COMMIT];
   logic [XLEN-1:0]            cm_val [NUM_COMMIT];
   logic                       issue_en;

   always_comb begin
      for (int c = 0; c < NUM_COMMIT; c++) begin
         cm_rd[c]  = bus.commit_rd[c*REG_ADDR_W +: REG_ADDR_W];
         cm_tag[c] = bus.commit_tag[c*TAG_W +: TAG_W];
         cm_val[c] = bus.commit_value[c*XLEN +: XLEN];
      end
   end

   assign issue_en = bus.issue_valid && (bus.issue_rd != '0) && !bus.flush;

   // Later non-blocking writes win: younger commit ports over older, issue over
   // a commit's busy clear, flush over both.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
            tags[r] <= '0;
         end
         busy <= '0;
      end else if (bus.rdy) begin
         for (int c = 0; c < NUM_COMMIT; c++) begin
            if (bus.commit_valid[c] && cm_rd[c] != '0) begin
               regs[cm_rd[c]] <= cm_val[c];
               if (tags[cm_rd[c]] == cm_tag[c])
                  busy[cm_rd[c]] <= 1'b0;
            end
         end
         if (issue_en) begin
            tags[bus.issue_rd] <= bus.issue_tag;
            busy[bus.issue_rd] <= 1'b1;
         end
         if (bus.flush) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++)
               tags[r] <= '0;
         end
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
      assign reg_flat[r*XLEN +: XLEN]   = regs[r];
      assign tag_flat[r*TAG_W +: TAG_W] = tags[r];
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      rf_read_port #(
         .XLEN         (XLEN),
         .TAG_W        (TAG_W)
`ifdef RF_COMMIT_FWD_EN
         , .NUM_COMMIT (NUM_COMMIT)
`endif
      ) u_port (
         .addr         (bus.rd_addr[p*REG_ADDR_W +: REG_ADDR_W]),
         .reg_flat     (reg_flat),
         .tag_flat     (tag_flat),
         .busy_flat    (busy),
`ifdef RF_COMMIT_FWD_EN
         .commit_valid (bus.commit_valid),
         .commit_tag   (bus.commit_tag),
         .commit_rd    (bus.commit_rd),
         .commit_value (bus.commit_value),
`endif
         .val          (bus.rd_val[p*XLEN +: XLEN]),
         .tag          (bus.rd_tag[p*TAG_W +: TAG_W]),
         .busy         (bus.rd_busy[p])
      );
   end
endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Architectural register file with per-register rename tags (ROB index) for the out-of-order core, parametrised in data width, ROB tag width, read-port count and commit width.
- Sits between the issue unit, which reads operands/dependencies and renames rd, and the ROB, which commits up to NUM_COMMIT results per cycle.
- Provides same-cycle commit-to-read forwarding and full flush on misprediction.

Parameters:
XLEN, 32, data width of each register
TAG_W, 6, ROB index width
NUM_READ, 2, number of operand read ports
NUM_COMMIT, 2, ROB commit ports per cycle; higher index = younger instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; state frozen when low
commit_valid  in  NUM_COMMIT  per-port commit strobe
commit_tag  in  NUM_COMMIT*TAG_W  ROB index of committing instruction
commit_rd  in  NUM_COMMIT*5  destination register
commit_value  in  NUM_COMMIT*XLEN  result value
issue_valid  in  1  rename strobe
issue_rd  in  5  register being renamed
issue_tag  in  TAG_W  new ROB index for issue_rd
rd_addr  in  NUM_READ*5  operand register per read port
rd_val  out  NUM_READ*XLEN  operand value
rd_tag  out  NUM_READ*TAG_W  producing ROB index; 0 when no dependency
rd_busy  out  NUM_READ  operand still pending
flush  in  1  pipeline flush from CDB

Behaviour:
- Clock/reset: reset rst, synchronous, active-high; clock clk. Reset clears all values, tags and busy bits. Reads after reset return val=0, tag=0, busy=0.
- rdy low: no state update. Read outputs remain combinationally valid.
- x0: always reads val=0, busy=0, tag=0. Commits and issues to x0 are ignored.
- Read ports are combinational, with zero latency. For each port p with addr a:
  - A match is commit port c with commit_valid[c], commit_rd[c]==a, a!=0 and commit_tag[c]==tag[a].
  - If any match exists, forward the highest-index matching value and drive busy=0, tag=0.
  - Otherwise drive val=reg[a], busy=busy[a], and tag=tag[a] if busy else 0.
  - Reads see pre-issue state; an issue in the same cycle never affects its own operand reads.
- Commit (clocked), for each valid port with rd!=0:
  - reg[rd] <= value. If several ports target the same rd, the highest index wins.
  - busy[rd] clears only if tag[rd]==commit_tag and no issue to the same rd occurs this cycle.
- Issue (clocked), when issue_valid and issue_rd!=0: tag[rd] <= issue_tag and busy[rd] <= 1. Issue has priority over a same-cycle busy clear.
- Flush (clocked): clears all busy and tag bits and suppresses issue. Commit value writes in the flush cycle are still applied, because the ROB head commits before the flush.
- Simultaneous commit of tag T and issue of tag T to the same rd: busy remains set and the new tag is T (ROB index reuse). This is legal.
- No internal FSM beyond per-register state. All behaviour is fully synchronous.

Optional Feature:
- Macro RF_COMMIT_FWD_EN.
- Defined: commit-to-read forwarding as above.
- Undefined: read ports return stored state only. A register committed this cycle still reads busy=1 with its old tag, and the issue unit waits for the CDB broadcast. This saves NUM_READ*NUM_COMMIT comparators.
- All sequential behaviour is identical in both modes.

Decomposition:
- Shared package holds:
  - XLEN, TAG_W, NUM_REGS=32, REG_ADDR_W=5
  - ZERO_TAG constant
  - a commit-bundle typedef (valid, tag, rd, value)
- Natural sub-module: rf_read_port, one instance per read port. It holds the forwarding comparator and priority mux, with state arrays passed in as flattened vectors.

Test Plan:
- Reset, then read x5 and x0 -> val=0, busy=0, tag=0 on both ports.
- Issue rd=3 tag=7; next cycle read x3 -> busy=1, tag=7. Commit port0 tag=7 rd=3 value=0xDEADBEEF: the same cycle read gives 0xDEADBEEF with busy=0 (busy=1, tag=7 without RF_COMMIT_FWD_EN). The following cycle gives busy=0.
- Issue rd=4 tag=9, then issue rd=4 tag=12, then commit tag=9 rd=4 value=5 -> reg x4=5, busy stays 1, tag=12.
- In the same cycle, commit tag=12 rd=4 and issue rd=4 tag=20 -> next cycle busy=1, tag=20, value updated.
- Commit port0 rd=6 value=1 and port1 rd=6 value=2 in one cycle -> x6=2.
- Busy x1, x2, x3; assert flush with issue rd=8 and commit rd=1 value=0x55 -> next cycle all busy=0, x8 not busy, x1=0x55.
- rdy low during issue/commit -> no state change. Reset asserted while busy bits set -> all cleared next cycle.
